// File: rtl/exp_lut_arbiter.sv
`default_nettype none
// ============================================================================
// exp_lut_arbiter: round-robin sharing of a single exp_lut among NUM_REQ users
// Rev 1.0
// ============================================================================
module exp_lut_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int WAIT_CYCLES = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NUM_REQ-1:0]    i_req_valid,
  output logic [NUM_REQ-1:0]    o_req_ready,
  input  logic [NUM_REQ*64-1:0] i_req_value,
  output logic [NUM_REQ-1:0]    o_resp_valid,
  input  logic [NUM_REQ-1:0]    i_resp_ready,
  output logic [63:0]           o_resp_value,
  output logic [63:0]           o_lut_input,
  input  logic [63:0]           i_lut_exp,
  output logic                  o_busy,
  output logic [31:0]           o_done_count
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   gnt_q, gnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [63:0]        lut_in_q, lut_in_d;
  logic [63:0]        result_q, result_d;
  logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
  logic               busy_q, busy_d;
  logic [31:0]        done_cnt_q, done_cnt_d;

  logic               found;
  logic [IDX_W-1:0]   pick;
  logic [IDX_W-1:0]   cand;
  logic [63:0]        sel_value;

  // First valid requester after the last grant, wrapping modulo NUM_REQ.
  always_comb begin : rr_pick
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(last_q) + i) % NUM_REQ);
      if (!found && i_req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin : value_mux
    sel_value = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick == IDX_W'(k)) sel_value = i_req_value[64*k +: 64];
    end
  end

  always_comb begin : fsm_next
    state_d      = state_q;
    last_d       = last_q;
    gnt_d        = gnt_q;
    cnt_d        = cnt_q;
    lut_in_d     = lut_in_q;
    result_d     = result_q;
    resp_valid_d = resp_valid_q;
    done_cnt_d   = done_cnt_q;
    o_req_ready  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          o_req_ready[pick] = 1'b1;
          lut_in_d          = sel_value;
          last_d            = pick;
          gnt_d             = pick;
          cnt_d             = CNT_LOAD;
          state_d           = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // The LUT output is only trusted once the settle window has elapsed.
        if (cnt_q == '0) begin
          result_d            = i_lut_exp;
          resp_valid_d        = '0;
          resp_valid_d[gnt_q] = 1'b1;
          state_d             = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (i_resp_ready[gnt_q]) begin
          done_cnt_d   = done_cnt_q + 32'd1;
          resp_valid_d = '0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      last_q       <= LAST_RST;
      gnt_q        <= '0;
      cnt_q        <= '0;
      lut_in_q     <= '0;
      result_q     <= '0;
      resp_valid_q <= '0;
      busy_q       <= 1'b0;
      done_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      gnt_q        <= gnt_d;
      cnt_q        <= cnt_d;
      lut_in_q     <= lut_in_d;
      result_q     <= result_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
      done_cnt_q   <= done_cnt_d;
    end
  end

  assign o_resp_valid = resp_valid_q;
  assign o_resp_value = result_q;
  assign o_lut_input  = lut_in_q;
  assign o_busy       = busy_q;
  assign o_done_count = done_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_exp_lut_arbiter.sv
`default_nettype none
// ============================================================================
// tb_exp_lut_arbiter: table-driven and scoreboard bench for exp_lut_arbiter
// Rev 1.0
// ============================================================================
module tb_exp_lut_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int WAIT_CYCLES = 3;
  localparam logic [63:0] XMASK = 64'hA5A5_A5A5_0000_0000;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ-1:0]    o_req_ready;
  logic [NUM_REQ*64-1:0] req_value = '0;
  logic [NUM_REQ-1:0]    o_resp_valid;
  logic [NUM_REQ-1:0]    resp_ready = '0;
  logic [63:0]           o_resp_value;
  logic [63:0]           o_lut_input;
  logic [63:0]           lut_exp;
  logic                  o_busy;
  logic [31:0]           o_done_count;

  logic                  lut_ovr = 1'b0;
  logic [63:0]           lut_ovr_val = '0;
  logic                  sb_en = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  function automatic logic [63:0] lut_model(input logic [63:0] x);
    return x ^ XMASK;
  endfunction

  assign lut_exp = lut_ovr ? lut_ovr_val : lut_model(o_lut_input);

  exp_lut_arbiter #(.NUM_REQ(NUM_REQ), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_value  (req_value),
    .o_resp_valid (o_resp_valid),
    .i_resp_ready (resp_ready),
    .o_resp_value (o_resp_value),
    .o_lut_input  (o_lut_input),
    .i_lut_exp    (lut_exp),
    .o_busy       (o_busy),
    .o_done_count (o_done_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req_ready"},  64'(o_req_ready), 0);
    chk({tag, "_resp_valid"}, 64'(o_resp_valid), 0);
    chk({tag, "_resp_value"}, o_resp_value, 0);
    chk({tag, "_lut_input"},  o_lut_input, 0);
    chk({tag, "_busy"},       64'(o_busy), 0);
    chk({tag, "_done"},       64'(o_done_count), 0);
  endtask

  task automatic wait_idle(input string tag);
    int c;
    for (c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!o_busy) break;
      cyc();
    end
    chk({tag, "_idle_timeout"}, 64'(o_busy), 0);
    cyc();
  endtask

  // Scoreboard: expectation pushed at request handshake, popped at response handshake.
  typedef struct packed {
    logic [NUM_REQ-1:0] oh;
    logic [63:0]        val;
  } exp_t;
  exp_t sbq[$];

  always @(negedge clk) begin
    exp_t e;
    if (sb_en && rst_n) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (o_req_ready[k] && req_valid[k]) begin
          e.oh  = o_req_ready;
          e.val = lut_model(req_value[k*64 +: 64]);
          sbq.push_back(e);
        end
      end
      if (|(o_resp_valid & resp_ready)) begin
        if (sbq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_underflow: response 0x%016h with no pending request", o_resp_value);
        end else begin
          e = sbq.pop_front();
          chk("sb_resp_valid", 64'(o_resp_valid), 64'(e.oh));
          chk("sb_resp_value", o_resp_value, e.val);
        end
      end
    end
  end

  typedef struct {
    int                 req;
    logic [63:0]        val;
    logic [NUM_REQ-1:0] rdy;
    logic [63:0]        resp;
    int                 stall;
  } vec_t;
  vec_t vecs[4];

  initial begin
    int done_exp;
    int g_cnt, last_c, gidx, seen;

    vecs[0] = '{2, 64'h0000_0000_8000_0000, 4'b0100, 64'hA5A5_A5A5_8000_0000, 0};
    vecs[1] = '{0, 64'h1234_5678_9ABC_DEF0, 4'b0001, 64'hB791_F3DD_9ABC_DEF0, 9};
    vecs[2] = '{3, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 64'h5A5A_5A5A_FFFF_FFFF, 0};
    vecs[3] = '{1, 64'h8000_0000_0000_0001, 4'b0010, 64'h25A5_A5A5_0000_0001, 2};

    rst_n = 1'b0;
    cyc();
    cyc();
    chk_reset("reset");
    rst_n = 1'b1;
    sb_en = 1'b1;
    done_exp = 0;
    cyc();

    for (int r = 0; r < 4; r++) begin
      req_valid = '0;
      req_valid[vecs[r].req] = 1'b1;
      req_value[64*vecs[r].req +: 64] = vecs[r].val;
      resp_ready = (vecs[r].stall == 0) ? 4'hF : 4'h0;
      @(negedge clk);
      chk("req_ready", 64'(o_req_ready), 64'(vecs[r].rdy));
      chk("busy_c0", 64'(o_busy), 0);
      cyc();
      req_valid = '0;
      @(negedge clk);
      chk("lut_input", o_lut_input, vecs[r].val);
      chk("busy_c1", 64'(o_busy), 1);
      cyc();
      cyc();
      @(negedge clk);
      chk("no_early_resp", 64'(o_resp_valid), 0);
      cyc();
      @(negedge clk);
      chk("resp_valid", 64'(o_resp_valid), 64'(vecs[r].rdy));
      chk("resp_value", o_resp_value, vecs[r].resp);
      if (vecs[r].stall > 0) begin
        for (int s = 0; s < vecs[r].stall; s++) begin
          cyc();
          req_valid = ~vecs[r].rdy;
          @(negedge clk);
          chk("bp_valid", 64'(o_resp_valid), 64'(vecs[r].rdy));
          chk("bp_value", o_resp_value, vecs[r].resp);
          chk("bp_no_ready", 64'(o_req_ready), 0);
        end
        cyc();
        req_valid  = '0;
        resp_ready = 4'hF;
        @(negedge clk);
        chk("bp_release_valid", 64'(o_resp_valid), 64'(vecs[r].rdy));
      end
      cyc();
      done_exp++;
      @(negedge clk);
      chk("idle_after_resp", 64'(o_busy), 0);
      chk("done_count", 64'(o_done_count), 64'(done_exp));
      cyc();
    end

    // Fairness: all requesters saturating, responses always accepted.
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    done_exp = 0;
    for (int k = 0; k < NUM_REQ; k++) req_value[64*k +: 64] = 64'h0101_0000_0000_0100 * 64'(k + 1);
    req_valid  = 4'hF;
    resp_ready = 4'hF;
    g_cnt  = 0;
    last_c = 0;
    for (int c = 0; c < 60 && g_cnt < 6; c++) begin
      @(negedge clk);
      if (o_req_ready != '0) begin
        gidx = 0;
        for (int k = 0; k < NUM_REQ; k++) if (o_req_ready[k]) gidx = k;
        chk("rr_order", 64'(gidx), 64'(g_cnt % NUM_REQ));
        if (g_cnt > 0) chk("rr_spacing", 64'(c - last_c), 64'(WAIT_CYCLES + 2));
        last_c = c;
        g_cnt++;
      end
      cyc();
    end
    chk("rr_grant_count", 64'(g_cnt), 6);
    req_valid = '0;
    wait_idle("rr_drain");
    done_exp = 6;
    chk("rr_done_count", 64'(o_done_count), 64'(done_exp));

    // Capture timing: only the LUT value present on the final WAIT edge is kept.
    sb_en = 1'b0;
    lut_ovr = 1'b1;
    lut_ovr_val = 64'hDEAD_0000_0000_0000;
    req_valid = 4'b0010;
    req_value[64 +: 64] = 64'h0000_0001_0000_0000;
    cyc();
    req_valid = '0;
    lut_ovr_val = 64'h1111_1111_1111_1111;
    cyc();
    lut_ovr_val = 64'h2222_2222_2222_2222;
    cyc();
    lut_ovr_val = 64'h3333_3333_3333_3333;
    cyc();
    lut_ovr_val = 64'h4444_4444_4444_4444;
    @(negedge clk);
    chk("cap_valid", 64'(o_resp_valid), 64'(4'b0010));
    chk("cap_value", o_resp_value, 64'h3333_3333_3333_3333);
    cyc();
    lut_ovr = 1'b0;
    done_exp++;
    @(negedge clk);
    chk("cap_done", 64'(o_done_count), 64'(done_exp));
    cyc();

    // Reset asserted while the request is in WAIT.
    req_valid = 4'b0100;
    req_value[128 +: 64] = 64'h0000_0042_0000_0000;
    @(negedge clk);
    chk("rst_pre_ready", 64'(o_req_ready), 64'(4'b0100));
    cyc();
    req_valid = '0;
    cyc();
    #2 rst_n = 1'b0;
    #1;
    chk_reset("rst_async");
    cyc();
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (o_resp_valid != '0) seen++;
      cyc();
    end
    chk("rst_no_resp", 64'(seen), 0);
    req_valid = 4'b1001;
    @(negedge clk);
    chk("rst_first_grant", 64'(o_req_ready), 64'(4'b0001));
    cyc();
    req_valid = '0;
    wait_idle("rst_drain");
    chk("rst_done_count", 64'(o_done_count), 1);

    // Completion counter wrap.
    sb_en = 1'b1;
    force dut.done_cnt_q = 32'hFFFF_FFFF;
    #1;
    chk("wrap_preload", 64'(o_done_count), 64'h0000_0000_FFFF_FFFF);
    release dut.done_cnt_q;
    req_valid = 4'b1000;
    req_value[192 +: 64] = 64'h0000_0000_0000_0007;
    cyc();
    req_valid = '0;
    wait_idle("wrap_drain");
    chk("wrap_done_count", 64'(o_done_count), 0);

    chk("sb_empty", 64'(sbq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/exp_lut_arbiter.md
# exp_lut_arbiter

Round-robin controller that shares one `exp_lut` instance among `NUM_REQ` requesters in the quoting pipeline, for example the reservation-price and spread calculators.

- Accepts one q32.32 request at a time over a valid/ready handshake.
- Holds the LUT input register stable for a programmable number of settle cycles. This covers the multicycle path through the LUT's scale multiply and memory read.
- Captures the exponential result and returns it to the granted requester over a second valid/ready handshake.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters; must be ≥2.
- `WAIT_CYCLES`, default 3: settle cycles between LUT input update and result capture; must be ≥1.

Ports:
- `i_clk`, input, 1: the single clock.
- `i_rst_n`, input, 1: asynchronous, active-low reset.
- `i_req_valid`, input, `NUM_REQ`: per-requester request valid.
- `o_req_ready`, output, `NUM_REQ`: per-requester accept; one-hot or zero.
- `i_req_value`, input, `NUM_REQ`×64: packed signed q32.32 operands. Requester k occupies bits [64k+63:64k].
- `o_resp_valid`, output, `NUM_REQ`: per-requester response valid; one-hot or zero.
- `i_resp_ready`, input, `NUM_REQ`: per-requester response accept.
- `o_resp_value`, output, 64: shared result bus; meaningful only while `o_resp_valid` is set.
- `o_lut_input`, output, 64: registered drive to the LUT `input_value`.
- `i_lut_exp`, input, 64: from the LUT `exp_value`.
- `o_busy`, output, 1: high whenever the FSM is not in IDLE.
- `o_done_count`, output, 32: completed-response counter; wraps at 2^32.

## Operation
FSM states: IDLE, WAIT, RESP.

**Reset values:**
- State: IDLE.
- `o_lut_input`, result register, `o_resp_value`, `o_done_count`: 0.
- `o_req_ready`, `o_resp_valid`: 0.
- `o_busy`: 0.
- Grant pointer `last`: `NUM_REQ-1`, so requester 0 wins first.

**IDLE:**
- Grant selection: scan indices `last+1`, `last+2`, … modulo `NUM_REQ`; the first one with `i_req_valid` set is granted.
- `o_req_ready[g]` is asserted combinationally in the same cycle. This cycle is the handshake.
- On the edge:
  - `o_lut_input` ← `i_req_value[g]`.
  - `last` ← g.
  - Grant index register ← g.
  - Counter ← `WAIT_CYCLES-1`.
  - State → WAIT.
- If no request is valid, the FSM stays in IDLE with all readies 0.

**WAIT:**
- If the counter is 0: result register ← `i_lut_exp`, state → RESP.
- Otherwise the counter decrements.
- `o_lut_input` is held constant throughout.
- `i_lut_exp` is sampled only on the final WAIT edge; earlier values are ignored.

**RESP:**
- `o_resp_valid[g]` is 1.
- `o_resp_value` equals the result register.
- When `i_resp_ready[g]` is high: `o_done_count` increments by 1 (wrapping), and state → IDLE.
- `i_resp_ready` bits other than g are ignored.

**Ready rules:**
- `o_req_ready` is 0 outside IDLE.
- Only one request is ever outstanding.
- New requests arriving in WAIT or RESP wait; they are not dropped.

**Requester obligations:**
- Hold `i_req_valid` and `i_req_value` stable until the handshake.
- The arbiter does not check stability.

**Other rules:**
- Values pass through unmodified; clamping and scaling remain the LUT's job.
- Simultaneous requests: exactly one grant per IDLE cycle, in round-robin order. A requester that holds valid continuously is served within `NUM_REQ` grants.
- Reset mid-operation: state returns to IDLE asynchronously. The outstanding request is discarded with no response. The requester must re-issue it.

## Timing
- Request handshake in cycle 0.
- `o_lut_input` carries the new operand from cycle 1.
- WAIT occupies cycles 1 to `WAIT_CYCLES`.
- `o_resp_valid` is first high in cycle `WAIT_CYCLES+1`.
- With `i_resp_ready` already high, the response handshake completes in that cycle. The next grant is then possible in cycle `WAIT_CYCLES+2`.
- Minimum issue interval: `WAIT_CYCLES+2` cycles.
- `o_busy` is high from cycle 1 through the response handshake cycle inclusive.
- Backpressure: `o_resp_valid` and `o_resp_value` stay stable for as long as `i_resp_ready[g]` is low. No timeout.
- All outputs except `o_req_ready` are registered. `o_req_ready` is combinational from `i_req_valid`, state and `last`.

## Test plan
- **Single request:** `WAIT_CYCLES`=3; requester 2 sends `0x0000_0000_8000_0000` in cycle 0; the LUT model returns `input ^ 0xA5A5_A5A5_0000_0000`.
  - `o_req_ready`=0b0100 in cycle 0.
  - `o_lut_input`=`0x0000_0000_8000_0000` from cycle 1.
  - `o_resp_valid`=0b0100 in cycle 4, with `o_resp_value`=`0xA5A5_A5A5_8000_0000`.
  - `o_done_count`=1 after the handshake.
- **Round-robin fairness:** all four valids held high and `i_resp_ready` tied high → grant sequence 0, 1, 2, 3, 0, 1, with grants spaced 5 cycles apart.
- **Backpressure:** `i_resp_ready` held low for 10 cycles in RESP.
  - `o_resp_valid` and `o_resp_value` are stable.
  - `o_req_ready` stays 0 despite other valids.
  - Releasing ready → IDLE on the next cycle.
- **Capture timing:** `i_lut_exp` toggles every cycle during WAIT → result equals the value present on the final WAIT edge (cycle 3) only.
- **Reset mid-WAIT:** `i_rst_n` pulsed low in cycle 2.
  - All outputs return to reset values immediately.
  - No `o_resp_valid` appears.
  - After release, requester 0 is granted first when requesters 0 and 3 are both valid.
- **Counter wrap:** preload `o_done_count` near wrap via a forced value of `0xFFFF_FFFF`; one completion → 0.
